pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage semiMIPS pipeline. It merges the load-use request from the hazard detection unit, the EX-stage branch-taken flag, the multi-cycle multiply/divide start and the data-memory wait line. From these it drives the PC enable, the IF/ID and ID/EX write/flush/bubble controls and the EX/MEM bubble. It owns a down-counter that holds the pipeline frozen for the fixed latency of the multi-cycle multiply/divide unit.

## Interface
- MDCYCLES, 32, total frozen cycles per mul/div op, including the start cycle; legal range 2..255
- CNTW, 16, width of the stall-cycle counter
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- lduse  in  1  load-use hazard from hazard detection unit
- brtaken  in  1  branch/jump resolved taken in EX
- mdstart  in  1  mul/div instruction present in EX; held until it advances
- dmemwait  in  1  data memory not ready
- pcen  out  1  PC write enable
- ifidregwr  out  1  IF/ID write enable
- ifidflush  out  1  IF/ID clear to NOP
- ctrlsig  out  1  select NOP controls into ID/EX (bubble)
- idexregwr  out  1  ID/EX write enable
- exmembubble  out  1  EX/MEM captures NOP
- exmemregwr  out  1  EX/MEM write enable
- mdbusy  out  1  mul/div in progress
- mddone  out  1  mul/div result valid this cycle
- stallcnt  out  CNTW  cycles with pcen=0 since reset

## Operation
- States: RUN, MDWAIT, MDDONE. An 8-bit counter `cnt` is used in MDWAIT.
- Outputs are combinational from state, `cnt` and inputs. State, `cnt` and `stallcnt` are registered.
- Idle output vector: pcen=1, ifidregwr=1, idexregwr=1, exmemregwr=1. All other outputs are 0.
- Priority, highest first: dmemwait > mul/div (mdstart or MDWAIT) > brtaken > lduse.
- dmemwait=1 in any state:
  - pcen=0, ifidregwr=0, idexregwr=0, exmemregwr=0. All other outputs are 0, except mdbusy, which follows the state.
  - State does not change, except that `cnt` keeps decrementing in MDWAIT.
- RUN, mdstart=1, dmemwait=0 (the mdstart cycle):
  - Freeze: pcen=0, ifidregwr=0, idexregwr=0. exmembubble=1, exmemregwr=1, mdbusy=1.
  - `cnt` is loaded with MDCYCLES-1 and the next state is MDWAIT.
- MDWAIT:
  - Same freeze outputs as the mdstart cycle. `cnt` decrements by 1 per cycle.
  - When `cnt`==1, the next state is MDDONE.
- MDDONE:
  - mddone=1, mdbusy=0, outputs at the idle vector, so the pipeline advances.
  - The next state is RUN.
  - If dmemwait=1, the block stays in MDDONE frozen until dmemwait drops.
- RUN, brtaken=1: ifidflush=1, ctrlsig=1, pcen=1 (PC loads the target). Any lduse in the same cycle is ignored.
- RUN, lduse=1 alone: pcen=0, ifidregwr=0, ctrlsig=1. The request is level-driven; there is no extra state.
- mdstart and brtaken both come from EX and are mutually exclusive. If both are asserted, mdstart wins.
- mdstart and lduse in the same cycle: the mul/div freeze subsumes the bubble, so ctrlsig=0.
- stallcnt: increments on each clock edge where pcen=0. It saturates at all ones.

## Timing
- Request-to-control latency is 0 cycles (combinational). State changes take effect at the next rising edge.
- The mul/div op starting at edge-cycle T:
  - Frozen for cycles T .. T+MDCYCLES-1.
  - mddone=1 in cycle T+MDCYCLES, provided dmemwait=0.
- dmemwait during MDWAIT does not extend the count. It delays only the MDDONE advance.
- Reset (rstn=0) at any time:
  - State=RUN, cnt=0, stallcnt=0 immediately.
  - Outputs take the idle vector immediately, regardless of inputs.
  - mdbusy=0 and mddone=0, even if reset lands mid-MDWAIT.
- First edge after rstn rises: normal evaluation.

## Configuration
- STALLCNT_EN defined: stallcnt counter is implemented as described.
- STALLCNT_EN undefined: no counter register; stallcnt is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then all inputs 0 for 5 cycles -> idle vector every cycle, stallcnt=0.
- MDCYCLES=4, mdstart=1 for 4 cycles -> pcen=0 and exmembubble=1 for 4 cycles, mdbusy=1 for 4 cycles. Fifth cycle: mddone=1, pcen=1. stallcnt=4.
- lduse=1 and brtaken=1 in the same cycle -> ifidflush=1, ctrlsig=1, pcen=1, stallcnt unchanged.
- MDCYCLES=4, mdstart at T, dmemwait=1 in cycles T+2..T+5 -> mddone is delayed to T+6. In T+4..T+5, all enables are 0 and mddone=0.
- rstn pulled low in cycle T+2 of a mul/div op -> the same cycle shows the idle vector and mdbusy=0. After release with mdstart=0: RUN, no mddone.
- Build without STALLCNT_EN, repeat the lduse stall for 3 cycles -> pcen=0 for 3 cycles, stallcnt stays 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage semiMIPS pipeline with a fixed-latency mul/div freeze.
// Optional feature macro: STALLCNT_EN (stall-cycle counter); when undefined stallcnt is tied to 0.
module pipeline_ctrl #(
  parameter int MDCYCLES = 32,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            lduse,
  input  logic            brtaken,
  input  logic            mdstart,
  input  logic            dmemwait,
  output logic            pcen,
  output logic            ifidregwr,
  output logic            ifidflush,
  output logic            ctrlsig,
  output logic            idexregwr,
  output logic            exmembubble,
  output logic            exmemregwr,
  output logic            mdbusy,
  output logic            mddone,
  output logic [CNTW-1:0] stallcnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MDWAIT = 2'd1,
    MDDONE = 2'd2
  } state_t;

  localparam logic [7:0] MD_LOAD = 8'(MDCYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // State and mul/div countdown registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and combinational pipeline controls
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pcen        = 1'b1;
    ifidregwr   = 1'b1;
    ifidflush   = 1'b0;
    ctrlsig     = 1'b0;
    idexregwr   = 1'b1;
    exmembubble = 1'b0;
    exmemregwr  = 1'b1;
    mdbusy      = 1'b0;
    mddone      = 1'b0;
    if (!rstn) begin
      state_d = RUN;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (dmemwait) begin
            pcen       = 1'b0;
            ifidregwr  = 1'b0;
            idexregwr  = 1'b0;
            exmemregwr = 1'b0;
          end else if (mdstart) begin
            pcen        = 1'b0;
            ifidregwr   = 1'b0;
            idexregwr   = 1'b0;
            exmembubble = 1'b1;
            mdbusy      = 1'b1;
            cnt_d       = MD_LOAD;
            state_d     = MDWAIT;
          end else if (brtaken) begin
            ifidflush = 1'b1;
            ctrlsig   = 1'b1;
          end else if (lduse) begin
            pcen      = 1'b0;
            ifidregwr = 1'b0;
            ctrlsig   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        MDWAIT: begin
          // The countdown runs through memory waits; only the MDDONE advance is held off.
          pcen      = 1'b0;
          ifidregwr = 1'b0;
          idexregwr = 1'b0;
          mdbusy    = 1'b1;
          cnt_d     = cnt_q - 8'd1;
          if (dmemwait) begin
            exmemregwr = 1'b0;
          end else begin
            exmembubble = 1'b1;
          end
          if (cnt_q == 8'd1) begin
            state_d = MDDONE;
          end else begin
            state_d = MDWAIT;
          end
        end
        MDDONE: begin
          if (dmemwait) begin
            pcen       = 1'b0;
            ifidregwr  = 1'b0;
            idexregwr  = 1'b0;
            exmemregwr = 1'b0;
          end else begin
            mddone  = 1'b1;
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

`ifdef STALLCNT_EN
  logic [CNTW-1:0] stallcnt_q, stallcnt_d;

  // Saturating count of cycles with the PC held
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (!pcen && (stallcnt_q != {CNTW{1'b1}})) begin
      stallcnt_d = stallcnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      stallcnt_d = stallcnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stallcnt_q <= {CNTW{1'b0}};
    end else begin
      stallcnt_q <= stallcnt_d;
    end
  end

  assign stallcnt = stallcnt_q;
`else
  assign stallcnt = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MDCYCLES=4, CNTW=4); stall-count expectations follow STALLCNT_EN.
module tb_pipeline_ctrl;

  logic       clk, rstn, lduse, brtaken, mdstart, dmemwait;
  logic       pcen, ifidregwr, ifidflush, ctrlsig, idexregwr;
  logic       exmembubble, exmemregwr, mdbusy, mddone;
  logic [3:0] stallcnt;

  pipeline_ctrl #(.MDCYCLES(4), .CNTW(4)) dut (
    .clk(clk), .rstn(rstn), .lduse(lduse), .brtaken(brtaken), .mdstart(mdstart),
    .dmemwait(dmemwait), .pcen(pcen), .ifidregwr(ifidregwr), .ifidflush(ifidflush),
    .ctrlsig(ctrlsig), .idexregwr(idexregwr), .exmembubble(exmembubble),
    .exmemregwr(exmemregwr), .mdbusy(mdbusy), .mddone(mddone), .stallcnt(stallcnt)
  );

  always #5 clk = ~clk;

  // Vector order: pcen ifidregwr ifidflush ctrlsig idexregwr exmembubble exmemregwr mdbusy mddone
  localparam logic [8:0] IDLE = 9'b110010100;
  localparam logic [8:0] FRZ  = 9'b000001110;
  localparam logic [8:0] BR   = 9'b111110100;
  localparam logic [8:0] LDU  = 9'b000110100;
  localparam logic [8:0] DONE = 9'b110010101;
  localparam logic [8:0] DW0  = 9'b000000000;
  localparam logic [8:0] DWB  = 9'b000000010;

  typedef struct packed {
    logic [8:0] v;
    logic [8:0] m;
    logic [3:0] sc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_stall = 4'd0;
  logic       last_pcen = 1'b1;

  function automatic logic [14:0] st(input logic dc, r, ld, br, md, dw, input logic [8:0] ev);
    return {dc, r, ld, br, md, dw, ev};
  endfunction

  function automatic logic [8:0] outv();
    return {pcen, ifidregwr, ifidflush, ctrlsig, idexregwr, exmembubble, exmemregwr, mdbusy, mddone};
  endfunction

  task automatic drive(input logic [14:0] s);
    exp_t e;
    rstn = s[13]; lduse = s[12]; brtaken = s[11]; mdstart = s[10]; dmemwait = s[9];
    if (!s[13]) m_stall = 4'd0;
    e.v = s[8:0];
    e.m = s[14] ? 9'b111111101 : 9'b111111111;
    e.sc = m_stall;
    sb.push_back(e);
    last_pcen = s[8];
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
`ifdef STALLCNT_EN
    if (rstn && !last_pcen && m_stall != 4'hF) m_stall = m_stall + 4'd1;
`endif
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] tab [7];
    exp_t e;
    tab = '{st(0,0,1,1,1,1,IDLE), st(0,0,1,0,0,1,IDLE), st(0,1,0,0,0,0,IDLE),
            st(0,1,0,0,0,0,IDLE), st(0,1,0,0,0,0,IDLE), st(0,1,0,0,0,0,IDLE),
            st(0,1,0,0,0,0,IDLE)};
    foreach (tab[i]) begin
      drive(tab[i]); e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL reset[%0d] ctrl got=%b exp=%b", i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL reset[%0d] stallcnt got=%0d exp=%0d", i, stallcnt, e.sc); end
      tick();
    end
  endtask

  task automatic test_muldiv();
    logic [14:0] tab [7];
    exp_t e;
    tab = '{st(0,0,0,0,0,0,IDLE), st(0,1,0,0,1,0,FRZ), st(0,1,0,0,1,0,FRZ),
            st(0,1,0,0,1,0,FRZ), st(0,1,0,0,1,0,FRZ), st(0,1,0,0,0,0,DONE),
            st(0,1,0,0,0,0,IDLE)};
    foreach (tab[i]) begin
      drive(tab[i]); e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL muldiv[%0d] ctrl got=%b exp=%b", i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL muldiv[%0d] stallcnt got=%0d exp=%0d", i, stallcnt, e.sc); end
      tick();
    end
  endtask

  task automatic test_priority();
    logic [14:0] tab [16];
    exp_t e;
    tab = '{st(0,0,0,0,0,0,IDLE), st(0,1,1,1,0,0,BR),   st(0,1,1,0,0,0,LDU),
            st(0,1,0,0,0,0,IDLE), st(0,1,1,0,1,0,FRZ),  st(0,1,1,0,1,0,FRZ),
            st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,0,0,DONE),
            st(0,1,0,1,1,0,FRZ),  st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,1,0,FRZ),
            st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,0,0,DONE), st(0,1,0,1,0,1,DW0),
            st(0,1,1,0,1,1,DW0)};
    foreach (tab[i]) begin
      drive(tab[i]); e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL priority[%0d] ctrl got=%b exp=%b", i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL priority[%0d] stallcnt got=%0d exp=%0d", i, stallcnt, e.sc); end
      tick();
    end
  endtask

  task automatic test_dmemwait_md();
    logic [14:0] tab [9];
    exp_t e;
    tab = '{st(0,0,0,0,0,0,IDLE), st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,1,0,FRZ),
            st(0,1,0,0,1,1,DWB),  st(0,1,0,0,1,1,DWB),  st(1,1,0,0,0,1,DW0),
            st(1,1,0,0,0,1,DW0),  st(0,1,0,0,0,0,DONE), st(0,1,0,0,0,0,IDLE)};
    foreach (tab[i]) begin
      drive(tab[i]); e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL dmemwait_md[%0d] ctrl got=%b exp=%b", i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL dmemwait_md[%0d] stallcnt got=%0d exp=%0d", i, stallcnt, e.sc); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] tab [8];
    exp_t e;
    tab = '{st(0,0,0,0,0,0,IDLE), st(0,1,0,0,1,0,FRZ),  st(0,1,0,0,1,0,FRZ),
            st(0,0,0,0,1,0,IDLE), st(0,1,0,0,0,0,IDLE), st(0,1,0,0,0,0,IDLE),
            st(0,1,0,0,0,0,IDLE), st(0,1,0,0,0,0,IDLE)};
    foreach (tab[i]) begin
      drive(tab[i]); e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL reset_mid[%0d] ctrl got=%b exp=%b", i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL reset_mid[%0d] stallcnt got=%0d exp=%0d", i, stallcnt, e.sc); end
      tick();
    end
  endtask

  task automatic test_lduse_stall(input int n);
    exp_t e;
    for (int i = 0; i < n + 2; i++) begin
      if (i == 0)          drive(st(0,0,0,0,0,0,IDLE));
      else if (i <= n)     drive(st(0,1,1,0,0,0,LDU));
      else                 drive(st(0,1,0,0,0,0,IDLE));
      e = sb.pop_front();
      checks++; if ((outv() & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL lduse%0d[%0d] ctrl got=%b exp=%b", n, i, outv(), e.v); end
      checks++; if (stallcnt !== e.sc) begin failures++; $display("FAIL lduse%0d[%0d] stallcnt got=%0d exp=%0d", n, i, stallcnt, e.sc); end
      tick();
    end
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0; lduse = 1'b0; brtaken = 1'b0; mdstart = 1'b0; dmemwait = 1'b0;
    test_reset();
    test_muldiv();
    test_priority();
    test_dmemwait_md();
    test_reset_mid();
    test_lduse_stall(3);
    test_lduse_stall(18);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
